sel_pipe_mux: RTL and testbench

Parametrised N-way operand select stage for the 19-bit datapath. It chooses one of NUM_IN WIDTH-bit sources and registers the result behind a valid/ready handshake. A 2-entry skid buffer lets it sit between pipeline stages at full throughput, with in_ready driven straight from a register. It replaces ad-hoc combinational 3:1 selects where the select path needs retiming and backpressure.

---
 rtl/sel_pipe_mux.sv | 147 ++++++++++++++
 tb/tb_sel_pipe_mux.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/sel_pipe_mux.sv
// N-way operand select behind a valid/ready handshake with a 2-entry skid buffer.
// in_ready comes straight from a flop so the upstream ready path is fully retimed.
module sel_pipe_mux #(
  parameter  int WIDTH  = 19,
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  // State bit 0 is out_valid, bit 1 is skid_valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_in_ready;
  logic [WIDTH-1:0]   r_out_data;
  logic [WIDTH-1:0]   r_skid_data;
  logic               r_sel_err;
  logic [WIDTH-1:0]   w_mux;
  logic               w_sel_oob;
  logic               w_accept;
  logic               w_deliver;
  logic               w_load_out;
  logic               w_load_skid;
  logic               w_skid_to_out;

  assign w_accept  = in_valid & r_in_ready;
  assign w_deliver = r_state[0] & out_ready;
  assign w_sel_oob = ({1'b0, sel} >= (SEL_W+1)'(NUM_IN));

  // Source select; out-of-range indices fall back to source 0.
  always_comb begin
    w_mux = in_data[0 +: WIDTH];
    for (int k = 1; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        w_mux = in_data[k*WIDTH +: WIDTH];
      end else begin
        w_mux = w_mux;
      end
    end
  end

  // State register plus the flopped in_ready that mirrors !skid_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= ~w_next[1];
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY: w_next = w_accept ? ST_ONE : ST_EMPTY;
      ST_ONE: begin
        if (w_accept && !w_deliver) begin
          w_next = ST_FULL;
        end else if (!w_accept && w_deliver) begin
          w_next = ST_EMPTY;
        end else begin
          w_next = ST_ONE;
        end
      end
      ST_FULL:  w_next = w_deliver ? ST_ONE : ST_FULL;
      default:  w_next = ST_EMPTY;
    endcase
  end

  // Datapath load decode.
  always_comb begin
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      ST_EMPTY: w_load_out    = w_accept;
      ST_ONE: begin
        w_load_out  = w_accept & w_deliver;
        w_load_skid = w_accept & ~w_deliver;
      end
      ST_FULL:  w_skid_to_out = w_deliver;
      default: begin
        w_load_out    = 1'b0;
        w_load_skid   = 1'b0;
        w_skid_to_out = 1'b0;
      end
    endcase
  end

  // Output and skid data registers; only written on an actual transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_out) begin
        r_out_data <= w_mux;
      end else if (w_skid_to_out) begin
        r_out_data <= r_skid_data;
      end else begin
        r_out_data <= r_out_data;
      end
      if (w_load_skid) begin
        r_skid_data <= w_mux;
      end else begin
        r_skid_data <= r_skid_data;
      end
    end
  end

  // Sticky select error; a new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && w_sel_oob) begin
      r_sel_err <= 1'b1;
    end else if (err_clr) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= r_sel_err;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_state[0];
  assign out_data  = r_out_data;
  assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Directed table plus hand sequences and a randomized scoreboard for sel_pipe_mux.
// u4 uses NUM_IN=4, u3 uses NUM_IN=3 for out-of-range select cases; both share stimulus.
module tb_sel_pipe_mux;

  localparam int W = 19;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, out_ready, err_clr;
  logic [1:0]           sel;
  logic [3:0][W-1:0]    src;
  logic [4*W-1:0]       in_data4;
  logic [3*W-1:0]       in_data3;
  logic                 in_ready4, out_valid4, sel_err4;
  logic                 in_ready3, out_valid3, sel_err3;
  logic [W-1:0]         out_data4, out_data3;

  int checks = 0;
  int errors = 0;

  assign in_data4 = src;
  assign in_data3 = src[2:0];

  always #5 clk = ~clk;

  sel_pipe_mux #(.WIDTH(W), .NUM_IN(4)) u4 (
    .clk(clk), .rst(rst), .in_data(in_data4), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .sel_err(sel_err4), .err_clr(err_clr));

  sel_pipe_mux #(.WIDTH(W), .NUM_IN(3)) u3 (
    .clk(clk), .rst(rst), .in_data(in_data3), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .sel_err(sel_err3), .err_clr(err_clr));

  typedef struct {
    logic         rst;
    logic         iv;
    logic         ordy;
    logic [1:0]   sel;
    logic [W-1:0] data;
    logic         e_valid;
    logic [W-1:0] e_data;
    logic         e_ready;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Put data into the selected slot and distinct filler everywhere else.
  task automatic set_src(input logic [1:0] s, input logic [W-1:0] d);
    for (int k = 0; k < 4; k++) src[k] = 19'h5A5A5 ^ W'(k * 19'h01111);
    src[s] = d;
  endtask

  int           beats;
  int           cyc;
  logic         acc, dlv, stall_prev;
  logic [W-1:0] od_prev;
  logic [W-1:0] q[$];
  logic [1:0]   rs;
  logic [W-1:0] rd;

  initial begin
    //          rst   iv    ordy  sel    data        ev    edata       erdy
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 2'd0, 19'h00000, 1'b0, 19'h00000, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 2'd0, 19'h00000, 1'b0, 19'h00000, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'd0, 19'h00011, 1'b1, 19'h00011, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 2'd1, 19'h00022, 1'b1, 19'h00022, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'd2, 19'h00033, 1'b1, 19'h00033, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'd3, 19'h7FFFF, 1'b1, 19'h7FFFF, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 2'd0, 19'h00001, 1'b0, 19'h7FFFF, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 19'h12345, 1'b1, 19'h12345, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2'd1, 19'h54321, 1'b1, 19'h12345, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 2'd2, 19'h0CCCC, 1'b1, 19'h12345, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 2'd2, 19'h0CCCC, 1'b1, 19'h54321, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 2'd2, 19'h0CCCC, 1'b1, 19'h0CCCC, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 2'd2, 19'h0CCCC, 1'b0, 19'h0CCCC, 1'b1};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0; sel = 2'd0;
    set_src(2'd0, 19'h00000);
    #1;

    // Reset, streaming and skid backpressure.
    foreach (tbl[i]) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv; out_ready = tbl[i].ordy; sel = tbl[i].sel;
      set_src(tbl[i].sel, tbl[i].data);
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid4), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_data", i),  32'(out_data4),  32'(tbl[i].e_data));
      chk($sformatf("tbl%0d_ready", i), 32'(in_ready4),  32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_err", i),   32'(sel_err4),   32'd0);
    end

    // Out-of-range select on NUM_IN=3: not accepted first, then accepted.
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; step();
    rst = 1'b0; sel = 2'd3; set_src(2'd0, 19'h0ABCD);
    step();
    chk("oob_noaccept_err", 32'(sel_err3), 32'd0);
    chk("oob_noaccept_valid", 32'(out_valid3), 32'd0);
    in_valid = 1'b1; step();
    chk("oob_data", 32'(out_data3), 32'h0ABCD);
    chk("oob_valid", 32'(out_valid3), 32'd1);
    chk("oob_err", 32'(sel_err3), 32'd1);
    chk("in_range4_err", 32'(sel_err4), 32'd0);

    // Set and clear in the same cycle: set wins; clear alone then clears.
    err_clr = 1'b1; step();
    chk("race_err", 32'(sel_err3), 32'd1);
    in_valid = 1'b0; step();
    chk("clear_err", 32'(sel_err3), 32'd0);
    err_clr = 1'b0;

    // Reset while both registers are occupied.
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0; set_src(2'd0, 19'h11111); step();
    set_src(2'd0, 19'h22222); step();
    chk("full_ready", 32'(in_ready4), 32'd0);
    rst = 1'b1; step();
    chk("rstfull_valid", 32'(out_valid4), 32'd0);
    chk("rstfull_ready", 32'(in_ready4), 32'd1);
    chk("rstfull_data", 32'(out_data4), 32'd0);
    rst = 1'b0; out_ready = 1'b1; set_src(2'd0, 19'h33333); step();
    chk("postrst_data", 32'(out_data4), 32'h33333);
    chk("postrst_valid", 32'(out_valid4), 32'd1);
    in_valid = 1'b0; step();
    chk("postrst_drain", 32'(out_valid4), 32'd0);

    // Random handshake against an in-order scoreboard.
    beats = 0; stall_prev = 1'b0; od_prev = '0;
    for (cyc = 0; cyc < 30000 && beats < 4000; cyc++) begin
      in_valid  = 1'($urandom_range(1, 0));
      out_ready = 1'($urandom_range(1, 0));
      rs        = 2'($urandom_range(3, 0));
      rd        = 19'($urandom);
      sel       = rs;
      set_src(rs, rd);
      if (stall_prev) chk("rand_stable", 32'(out_data4), 32'(od_prev));
      chk("rand_ready", 32'(in_ready4), 32'(q.size() < 2));
      chk("rand_valid", 32'(out_valid4), 32'(q.size() != 0));
      acc = in_valid & in_ready4;
      dlv = out_valid4 & out_ready;
      if (dlv) begin
        if (q.size() == 0) begin
          chk("rand_underflow", 32'd1, 32'd0);
        end else begin
          chk("rand_data", 32'(out_data4), 32'(q[0]));
          void'(q.pop_front());
          beats++;
        end
      end
      if (acc) q.push_back(rd);
      stall_prev = out_valid4 & ~out_ready;
      od_prev    = out_data4;
      step();
    end
    chk("rand_beats", 32'(beats), 32'd4000);
    chk("pow2_err", 32'(sel_err4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
